// File: rtl/md_sched_if.sv
// -----------------------------------------------------------------------------
// md_sched_if
//   Bundles the E-stage issue signals and the HI/LO/status results of the
//   multiply/divide scheduler.
//
//   Signals
//     start      issue strobe from the E stage (one cycle per instruction)
//     op         3-bit operation code (0 mult, 1 multu, 2 div, 3 divu,
//                4 mthi, 5 mtlo, 6/7 no-op)
//     a, b       forwarded rs / rt operands
//     d_uses_md  D-stage instruction touches HI/LO or the unit
//     hi, lo     architectural HI / LO registers
//     busy       an operation is in flight
//     stall      combinational stall request toward the D stage
//
//   Modports
//     master  pipeline side: drives issue signals, observes results
//     slave   scheduler side: observes issue signals, drives results
// -----------------------------------------------------------------------------
interface md_sched_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_uses_md;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;

  modport master (
    output start, op, a, b, d_uses_md,
    input  hi, lo, busy, stall
  );

  modport slave (
    input  start, op, a, b, d_uses_md,
    output hi, lo, busy, stall
  );
endinterface

// File: rtl/md_sched.sv
// -----------------------------------------------------------------------------
// md_sched
//   Multi-cycle multiply/divide scheduler for the 5-stage MIPS pipeline.
//   Accepts mult/multu/div/divu/mthi/mtlo from the E stage, holds the unit busy
//   for a fixed number of cycles and then commits the result to HI/LO.
//   A combinational stall request protects HI/LO users in the D stage.
//
//   Parameters
//     MULT_CYCLES  busy cycles for mult/multu (1..15)
//     DIV_CYCLES   busy cycles for div/divu   (1..15)
//
//   Ports
//     clk      pipeline clock, rising edge
//     reset_n  asynchronous active-low reset
//     bus      md_sched_if.slave: start/op/a/b/d_uses_md in,
//              hi/lo/busy/stall out
// -----------------------------------------------------------------------------
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  md_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN_MUL = 2'd1,
    RUN_DIV = 2'd2
  } state_t;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t      state_reg,  state_next;
  logic [3:0]  count_reg,  count_next;
  logic [31:0] a_reg,      a_next;
  logic [31:0] b_reg,      b_next;
  logic        signed_reg, signed_next;
  logic [31:0] hi_reg,     hi_next;
  logic [31:0] lo_reg,     lo_next;
  logic        busy_reg,   busy_next;

  // ---------------------------------------------------------------------------
  // Op decode
  // ---------------------------------------------------------------------------
  logic is_mul_op;
  logic is_div_op;
  logic is_mthi_op;
  logic is_mtlo_op;

  assign is_mul_op  = (bus.op == 3'd0) || (bus.op == 3'd1);
  assign is_div_op  = (bus.op == 3'd2) || (bus.op == 3'd3);
  assign is_mthi_op = (bus.op == 3'd4);
  assign is_mtlo_op = (bus.op == 3'd5);

  // ---------------------------------------------------------------------------
  // Multiplier: sign- or zero-extend both operands to 64 bits; the low 64 bits
  // of the 64x64 product are then correct for both signed and unsigned cases.
  // ---------------------------------------------------------------------------
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] product;

  assign ext_a   = {{32{signed_reg & a_reg[31]}}, a_reg};
  assign ext_b   = {{32{signed_reg & b_reg[31]}}, b_reg};
  assign product = ext_a * ext_b;

  // ---------------------------------------------------------------------------
  // Divider: divide magnitudes unsigned, then restore signs. The quotient
  // takes the xor of the operand signs (truncation toward zero) and the
  // remainder takes the sign of the dividend. Working on magnitudes makes
  // 0x80000000 / -1 fall out naturally as quotient 0x80000000, remainder 0.
  // ---------------------------------------------------------------------------
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic        div_zero;
  logic [31:0] safe_b;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  assign neg_a    = signed_reg & a_reg[31];
  assign neg_b    = signed_reg & b_reg[31];
  assign mag_a    = neg_a ? (~a_reg + 32'd1) : a_reg;
  assign mag_b    = neg_b ? (~b_reg + 32'd1) : b_reg;
  assign div_zero = (b_reg == 32'd0);
  // Divisor forced to 1 on divide-by-zero so the divider never sees zero;
  // the result is discarded in that case anyway.
  assign safe_b   = div_zero ? 32'd1 : mag_b;
  assign q_mag    = mag_a / safe_b;
  assign r_mag    = mag_a % safe_b;
  assign quot     = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
  assign rem      = neg_a ? (~r_mag + 32'd1) : r_mag;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      count_reg  <= 4'd0;
      a_reg      <= 32'd0;
      b_reg      <= 32'd0;
      signed_reg <= 1'b0;
      hi_reg     <= 32'd0;
      lo_reg     <= 32'd0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      signed_reg <= signed_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      busy_reg   <= busy_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    signed_next = signed_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    busy_next   = busy_reg;

    unique case (state_reg)
      IDLE: begin
        if (bus.start) begin
          if (is_mul_op || is_div_op) begin
            a_next      = bus.a;
            b_next      = bus.b;
            // Even op codes (mult, div) are the signed variants.
            signed_next = ~bus.op[0];
            busy_next   = 1'b1;
            if (is_mul_op) begin
              count_next = MULT_LOAD;
              state_next = RUN_MUL;
            end else begin
              count_next = DIV_LOAD;
              state_next = RUN_DIV;
            end
          end else if (is_mthi_op) begin
            hi_next = bus.a;
          end else if (is_mtlo_op) begin
            lo_next = bus.a;
          end
        end
      end

      // start is deliberately not looked at while running: an issue during
      // busy is a pipeline bug and must not disturb the in-flight operation.
      RUN_MUL: begin
        if (count_reg == 4'd1) begin
          hi_next    = product[63:32];
          lo_next    = product[31:0];
          count_next = 4'd0;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else begin
          count_next = count_reg - 4'd1;
        end
      end

      RUN_DIV: begin
        if (count_reg == 4'd1) begin
          // Divide-by-zero runs the full period but leaves HI/LO untouched.
          if (!div_zero) begin
            hi_next = rem;
            lo_next = quot;
          end
          count_next = 4'd0;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else begin
          count_next = count_reg - 4'd1;
        end
      end

      default: begin
        state_next = IDLE;
        count_next = 4'd0;
        busy_next  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs. The issue cycle of a mult/div already stalls a dependent D-stage
  // instruction; mthi/mtlo never stall on their own.
  // ---------------------------------------------------------------------------
  assign bus.hi    = hi_reg;
  assign bus.lo    = lo_reg;
  assign bus.busy  = busy_reg;
  assign bus.stall = bus.d_uses_md & (busy_reg | (bus.start & (bus.op <= 3'd3)));

endmodule

// File: tb/tb_md_sched.sv
// -----------------------------------------------------------------------------
// tb_md_sched
//   Directed self-checking bench for md_sched. Expected HI/LO pairs are pushed
//   to a scoreboard queue at issue and popped when busy falls.
// -----------------------------------------------------------------------------
module tb_md_sched;

  logic clk;
  logic reset_n;

  md_sched_if bus ();

  md_sched #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] sb_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) begin
      $display("[%0t] ok   %s obs=%h", $time, tag, obs);
    end else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // mthi (o=4) / mtlo (o=5): written at the issue edge, never stalls.
  task automatic mt(input logic [2:0] o, input logic [31:0] v, input string tag);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = v;
    #1;
    check({tag, " stall"}, {63'd0, bus.stall}, 64'd0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    if (o == 3'd4) check({tag, " hi"}, {32'd0, bus.hi}, {32'd0, v});
    else           check({tag, " lo"}, {32'd0, bus.lo}, {32'd0, v});
  endtask

  // Issue a mult/div, count busy cycles, then compare HI/LO from the
  // scoreboard. pulse_at>0 injects a stray start (op=0, a=b=1) at that busy
  // cycle, which must be ignored.
  task automatic do_op(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] eh, input logic [31:0] el,
                       input int n, input int pulse_at, input string tag);
    int cnt;
    logic [63:0] exp_res;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = va;
    bus.b     = vb;
    #1;
    check({tag, " issue stall"}, {63'd0, bus.stall}, {63'd0, bus.d_uses_md});
    sb_q.push_back({eh, el});
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    cnt = 0;
    @(negedge clk);
    while (bus.busy === 1'b1 && cnt < 40) begin
      cnt++;
      check({tag, " busy stall"}, {63'd0, bus.stall}, {63'd0, bus.d_uses_md});
      if (cnt == pulse_at) begin
        bus.start = 1'b1;
        bus.op    = 3'd0;
        bus.a     = 32'd1;
        bus.b     = 32'd1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    #1;
    check({tag, " busy cycles"}, 64'(cnt), 64'(n));
    exp_res = sb_q.pop_front();
    check({tag, " hi:lo"}, {bus.hi, bus.lo}, exp_res);
    check({tag, " stall after"}, {63'd0, bus.stall}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n       = 1'b0;
    bus.start     = 1'b0;
    bus.op        = 3'd7;
    bus.a         = 32'd0;
    bus.b         = 32'd0;
    bus.d_uses_md = 1'b0;
    repeat (3) @(negedge clk);
    check("reset hi",    {32'd0, bus.hi}, 64'd0);
    check("reset lo",    {32'd0, bus.lo}, 64'd0);
    check("reset busy",  {63'd0, bus.busy}, 64'd0);
    check("reset stall", {63'd0, bus.stall}, 64'd0);
    reset_n = 1'b1;

    // Reset in the middle of a mult: async clear, no late commit.
    mt(3'd4, 32'h0000_AAAA, "pre mthi");
    mt(3'd5, 32'h0000_BBBB, "pre mtlo");
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'd0;
    bus.a     = 32'd5;
    bus.b     = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrun busy", {63'd0, bus.busy}, 64'd1);
    reset_n = 1'b0;
    #1;
    check("midrun rst hi",   {32'd0, bus.hi}, 64'd0);
    check("midrun rst lo",   {32'd0, bus.lo}, 64'd0);
    check("midrun rst busy", {63'd0, bus.busy}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    check("post rst busy", {63'd0, bus.busy}, 64'd0);
    check("post rst hi:lo", {bus.hi, bus.lo}, 64'd0);

    // Multiplies
    do_op(3'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, 0, "mult -2*3");
    do_op(3'd1, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 5, 0, "multu");
    do_op(3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5, 0, "mult min*min");

    // Divides
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 0, "div -7/2");
    do_op(3'd3, 32'd7, 32'd2, 32'd1, 32'd3, 10, 0, "divu 7/2");
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10, 0, "div min/-1");
    do_op(3'd3, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC, 10, 0, "divu big/2");

    // Divide by zero keeps prior HI/LO
    mt(3'd4, 32'h0000_0011, "dz mthi");
    mt(3'd5, 32'h0000_0022, "dz mtlo");
    do_op(3'd2, 32'd5, 32'd0, 32'h0000_0011, 32'h0000_0022, 10, 0, "div by zero");

    // Stall: dependent D instruction across a mult, then an mthi
    bus.d_uses_md = 1'b1;
    do_op(3'd0, 32'd6, 32'd7, 32'd0, 32'd42, 5, 0, "stall mult");
    mt(3'd4, 32'h0000_0033, "stall mthi");
    bus.d_uses_md = 1'b0;

    // Stray issue during a div is ignored
    do_op(3'd2, 32'd100, 32'd7, 32'd2, 32'd14, 10, 3, "div ignore pulse");

    check("scoreboard empty", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
